// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial-add scheduler.
//   - state_e   : scheduler FSM states
//   - DefWidth  : default operand width
//   - DefNreq   : default requester count
//   - MaxReq    : widest request vector rr_select accepts
//   - rr_select : round-robin pick of the first set request at or after a pointer
package serial_add_pkg;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefNreq  = 2;
    localparam int unsigned MaxReq   = 32;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    // Returns the index of the first set bit of req at or after ptr, wrapping modulo nreq.
    // Falls back to ptr when no bit is set; callers only use the result when |req.
    function automatic int unsigned rr_select(input logic [MaxReq-1:0] req,
                                              input int unsigned       ptr,
                                              input int unsigned       nreq);
        int unsigned idx;
        logic        found;
        rr_select = ptr;
        found     = 1'b0;
        for (int unsigned k = 0; k < MaxReq; k++) begin
            if (k < nreq) begin
                idx = ptr + k;
                if (idx >= nreq) begin
                    idx = idx - nreq;
                end
                if (!found && req[idx[4:0]]) begin
                    rr_select = idx;
                    found     = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/serial_add_sched_if.sv
// Requester-side bus of the serial-add scheduler.
//   req    : per-requester level request
//   a_in   : operand A, requester i at [i*WIDTH +: WIDTH]
//   b_in   : operand B, same packing
//   grant  : one-hot acceptance pulse
//   busy   : operation in flight
//   owner  : current or last granted requester
//   done   : one-hot result-valid pulse to the owner
//   sum    : result, held until the next done
//   cout   : carry out of the MSB, held with sum
// master = requesters, slave = scheduler.
interface serial_add_sched_if
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned NREQ  = DefNreq,
    parameter int unsigned IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [IDW-1:0]        owner;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      sum;
    logic                  cout;

    modport master (
        output req, a_in, b_in,
        input  grant, busy, owner, done, sum, cout
    );

    modport slave (
        input  req, a_in, b_in,
        output grant, busy, owner, done, sum, cout
    );
endinterface

// File: rtl/serial_add_core.sv
// Bit-serial adder datapath: A/B/sum shift registers, 1-bit full adder, carry flop.
//   clk, reset   : clock and synchronous active-low reset
//   load         : capture a_load/b_load, clear the sum register
//   shift        : add one bit LSB-first and shift all registers right
//   clr_carry    : clear the carry flop
//   a_load/b_load: operands to capture on load
//   sum_next     : sum register value after the current shift
//   carry_next   : carry after the current bit
module serial_add_core
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             clr_carry,
    input  logic [WIDTH-1:0] a_load,
    input  logic [WIDTH-1:0] b_load,
    output logic [WIDTH-1:0] sum_next,
    output logic             carry_next
);
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             sum_bit;

    assign sum_bit    = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign sum_next   = {sum_bit, sum_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
        end else if (load) begin
            a_q   <= a_load;
            b_q   <= b_load;
            sum_q <= '0;
        end else if (shift) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            sum_q <= sum_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            carry_q <= 1'b0;
        end else if (clr_carry) begin
            carry_q <= 1'b0;
        end else if (shift) begin
            carry_q <= carry_next;
        end
    end
endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial adder among NREQ requesters.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : requester bus (slave side): req/a_in/b_in in; grant/busy/owner/done/sum/cout out
// An accepted request's operands are latched, added over WIDTH cycles, and the result is
// returned with a one-cycle done pulse to the owner.
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned NREQ  = DefNreq
) (
    input  logic              clk,
    input  logic              reset,
    serial_add_sched_if.slave bus
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(WIDTH);

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;

    logic              load, shift, clr_carry;
    logic [MaxReq-1:0] req_ext;
    logic [IDW-1:0]    win;
    logic [WIDTH-1:0]  a_sel, b_sel;
    logic [WIDTH-1:0]  sum_next;
    logic              carry_next;

    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = bus.req;
    end

    assign win   = IDW'(rr_select(req_ext, 32'(ptr_q), NREQ));
    assign a_sel = bus.a_in[win*WIDTH +: WIDTH];
    assign b_sel = bus.b_in[win*WIDTH +: WIDTH];

    serial_add_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .clr_carry (clr_carry),
        .a_load    (a_sel),
        .b_load    (b_sel),
        .sum_next  (sum_next),
        .carry_next(carry_next)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        grant_d   = '0;
        done_d    = '0;
        sum_d     = sum_q;
        cout_d    = cout_q;
        load      = 1'b0;
        shift     = 1'b0;
        clr_carry = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    load         = 1'b1;
                    clr_carry    = 1'b1;
                    cnt_d        = '0;
                    grant_d[win] = 1'b1;
                    owner_d      = win;
                    ptr_d        = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                    state_d      = StShift;
                end
            end
            StShift: begin
                shift = 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d           = sum_next;
                    cout_d          = carry_next;
                    done_d[owner_q] = 1'b1;
                    cnt_d           = '0;
                    state_d         = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.owner = owner_q;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.busy  = (state_q != StIdle);
endmodule

// File: doc/serial_add_sched.md
# serial_add_sched

Round-robin scheduler that shares one bit-serial adder datapath among `NREQ` requesters. It accepts a request, latches that requester's operands, and sequences the serial add LSB-first over `WIDTH` cycles with carry held in a flop. It then returns the sum and carry-out to the granted requester with a one-cycle done pulse. It sits in front of the serial adder datapath so several producers can use one adder without contention.

## Interface
- `WIDTH`, 4: operand/sum width in bits (≥2).
- `NREQ`, 2: number of requesters (≥2); `IDW = $clog2(NREQ)`.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low. Sampled on `clk` rising edge; 0 = reset.
- `req` in NREQ: per-requester level request.
- `a_in` in NREQ*WIDTH: operand A, requester i at bits `[i*WIDTH +: WIDTH]`.
- `b_in` in NREQ*WIDTH: operand B, same packing.
- `grant` out NREQ: one-hot, high for one cycle when a request is accepted.
- `busy` out 1: high while an operation is in flight (SHIFT or DONE).
- `owner` out IDW: index of the current or last granted requester.
- `done` out NREQ: one-hot, one-cycle pulse to the owner when the result is valid.
- `sum` out WIDTH: result, held until the next done.
- `cout` out 1: carry out of the MSB, held with `sum`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **Reset:** state IDLE, RR pointer 0. All of `grant`, `done`, `busy`, `owner`, `sum`, `cout`, the shift registers, the bit counter and the carry go to 0.
- **Reset mid-operation:** the in-flight operation is discarded and no `done` is issued.
- **IDLE:** if any `req` bit is high, select the first set bit at or after the RR pointer, wrapping modulo NREQ.
  - Latch that requester's A/B into the shift registers and clear the carry and counter.
  - Register `grant[w]=1` and `owner=w`, then go to SHIFT.
  - Set the RR pointer to (w+1) mod NREQ.
- **SHIFT:** each cycle, the sum bit is `a[0]^b[0]^c` and the new carry is the majority of `a[0]`, `b[0]`, `c`.
  - Shift A and B right and shift the sum bit into the sum register MSB.
  - Increment the counter. After the WIDTH-th bit, load `sum` and `cout`, register `done[owner]=1`, and go to DONE.
- **DONE:** one cycle, then return to IDLE.
- **Arithmetic:** `sum = (A+B) mod 2^WIDTH` and `cout = (A+B) >> WIDTH`. Operands are unsigned.
- **Requester contract:**
  - Hold `req` and operands stable until `grant`. Operands are not sampled after acceptance.
  - Drop `req` on seeing `done`. A `req` still high in IDLE is a new request.
- **Simultaneous requests:** the RR winner is granted; the others wait. There is no starvation, because every requester is served within NREQ operations.
- `req` changes during SHIFT or DONE are ignored.
- Only one requester is ever granted.

## Timing
- The request is sampled at IDLE edge E0. `grant` and `busy` are high in the cycle after E0.
- SHIFT performs one bit per edge, E1..E_WIDTH.
- `done`, `sum` and `cout` are valid in the cycle after E_WIDTH. This is WIDTH cycles after the `grant` cycle.
- `busy` falls on entry to IDLE.
- IDLE lasts at least one cycle, so back-to-back throughput is one operation per WIDTH+2 cycles.
- `sum` and `cout` change only on the edge that raises `done`.

## Structure
- Shared package `serial_add_pkg` holds:
  - the state enum (IDLE/SHIFT/DONE);
  - the default WIDTH and NREQ localparams;
  - the RR-select function, which takes the req vector and pointer and returns the index.
- Sub-module `serial_add_core` contains the 1-bit full adder, the carry flop and the A/B/sum shift registers. Its controls are `load`, `shift` and `clr_carry`.
- The scheduler holds the FSM, arbiter, counter, pointer and output registers.

## Test plan
- **Reset:** hold `reset=0` for 2 cycles with `req=2'b11` → all outputs 0 and no `grant`.
- **Single op:** requester 0 with A=1100, B=1101 → `grant=01`, then 4 cycles later `done=01`, `sum=1001`, `cout=1`. Second case: A=1010, B=1010 → `sum=0100`, `cout=1`.
- **Contention:** `req=11` held continuously with pointer 0 → grants alternate 01, 10, 01. Each `done` goes to the matching owner with the correct sums. Spacing is WIDTH+2 cycles.
- **Mid-operation operand change:** change `a_in[0]` to 1111 after `grant` → result still uses the latched operands (0011+0001 → `sum=0100`, `cout=0`).
- **Reset mid-SHIFT:** drive `reset=0` at bit 2 → no `done`, outputs 0. The next request computes 0101+0011 → `sum=1000`, `cout=0`.
- **Wrap and overflow:** A=1111, B=0001 → `sum=0000`, `cout=1`. A=0000, B=0000 → `sum=0000`, `cout=0`.
